// File: rtl/jp_input_conditioner.sv
// rtl/jp_input_conditioner.sv - NES joypad line sync, de-glitch, poll capture and presence detection
module jp_input_conditioner #(
  parameter int FILTER_LEN    = 3,
  parameter int PRESENT_POLLS = 2,
  parameter int ABSENT_POLLS  = 4
) (
  input  logic       clk_25,
  input  logic       rst,
  input  logic [1:0] jp_data_raw,
  input  logic       jp_latch,
  input  logic [1:0] jp_clk,
  output logic [1:0] jp_data_clean,
  output logic [1:0] jp_present,
  output logic [7:0] jp_buttons0,
  output logic [7:0] jp_buttons1,
  output logic       jp_poll_done
);

  typedef enum logic {ST_ABSENT = 1'b0, ST_PRESENT = 1'b1} pres_t;

  logic       latch_q;
  logic       started_q;
  logic       poll_done_q;
  logic       latch_rise;
  logic       eval;
  logic [7:0] btn_w [2];

  assign latch_rise   = jp_latch & ~latch_q;
  // The first latch after reset has no preceding poll to judge.
  assign eval         = latch_rise & started_q;
  assign jp_poll_done = poll_done_q;
  assign jp_buttons0  = btn_w[0];
  assign jp_buttons1  = btn_w[1];

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      latch_q     <= 1'b0;
      started_q   <= 1'b0;
      poll_done_q <= 1'b0;
    end else begin
      latch_q     <= jp_latch;
      started_q   <= started_q | latch_rise;
      poll_done_q <= eval;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [1:0] sync_q;
    logic       filt_q;
    logic [3:0] stab_q;
    logic       clk_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] btn_q;
    pres_t      state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [3:0] bad_q, bad_d;
    logic       btn_clr;
    logic       clk_rise;
    logic       complete;
    logic       tail_good;

    assign clk_rise  = jp_clk[p] & ~clk_q;
    assign complete  = eval && (bit_cnt_q == 4'd8);
    assign tail_good = ~filt_q;

    always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
        sync_q    <= 2'b11;
        filt_q    <= 1'b1;
        stab_q    <= 4'd0;
        clk_q     <= 1'b0;
        bit_cnt_q <= 4'd0;
        shift_q   <= 8'h00;
      end else begin
        sync_q <= {sync_q[0], jp_data_raw[p]};
        if (sync_q[1] == filt_q) begin
          stab_q <= 4'd0;
        end else if (stab_q == 4'(FILTER_LEN - 1)) begin
          filt_q <= sync_q[1];
          stab_q <= 4'd0;
        end else begin
          stab_q <= stab_q + 4'd1;
        end
        clk_q <= jp_clk[p];
        // A latch edge takes priority, so a coincident clock edge is lost.
        if (latch_rise) begin
          bit_cnt_q <= 4'd0;
        end else if (clk_rise && (bit_cnt_q < 4'd8)) begin
          shift_q[bit_cnt_q[2:0]] <= filt_q;
          bit_cnt_q               <= bit_cnt_q + 4'd1;
        end
      end
    end

    always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      btn_clr = 1'b0;
      if (complete) begin
        case (state_q)
          ST_ABSENT: begin
            if (!tail_good) begin
              good_d = 4'd0;
            end else if (good_q + 4'd1 == 4'(PRESENT_POLLS)) begin
              state_d = ST_PRESENT;
              good_d  = 4'd0;
              bad_d   = 4'd0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end
          default: begin
            if (tail_good) begin
              bad_d = 4'd0;
            end else if (bad_q + 4'd1 == 4'(ABSENT_POLLS)) begin
              state_d = ST_ABSENT;
              good_d  = 4'd0;
              bad_d   = 4'd0;
              btn_clr = 1'b1;
            end else begin
              bad_d = bad_q + 4'd1;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
      if (rst) begin
        state_q <= ST_ABSENT;
        good_q  <= 4'd0;
        bad_q   <= 4'd0;
        btn_q   <= 8'h00;
      end else begin
        state_q <= state_d;
        good_q  <= good_d;
        bad_q   <= bad_d;
        if (btn_clr) begin
          btn_q <= 8'h00;
        end else if (complete) begin
          btn_q <= ~shift_q;
        end
      end
    end

    assign jp_present[p]    = (state_q == ST_PRESENT);
    assign jp_data_clean[p] = filt_q | ~jp_present[p];
    assign btn_w[p]         = btn_q;
  end

endmodule

// File: tb/tb_jp_input_conditioner.sv
// tb/tb_jp_input_conditioner.sv - randomized poll bench with a behavioural pad/presence model
module tb_jp_input_conditioner;
  localparam int PRESENT_POLLS = 2;
  localparam int ABSENT_POLLS  = 4;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] jp_data_raw = 2'b00;
  logic       jp_latch = 1'b0;
  logic [1:0] jp_clk = 2'b00;
  logic [1:0] jp_data_clean;
  logic [1:0] jp_present;
  logic [7:0] jp_buttons0;
  logic [7:0] jp_buttons1;
  logic       jp_poll_done;

  jp_input_conditioner #(
    .FILTER_LEN(3), .PRESENT_POLLS(PRESENT_POLLS), .ABSENT_POLLS(ABSENT_POLLS)
  ) dut (
    .clk_25(clk_25), .rst(rst), .jp_data_raw(jp_data_raw), .jp_latch(jp_latch),
    .jp_clk(jp_clk), .jp_data_clean(jp_data_clean), .jp_present(jp_present),
    .jp_buttons0(jp_buttons0), .jp_buttons1(jp_buttons1), .jp_poll_done(jp_poll_done)
  );

  always #20 clk_25 = ~clk_25;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: remembers what the pad presented during the previous poll, judges it at the next latch.
  bit         m_started;
  bit         m_pres [2];
  int         m_good [2];
  int         m_bad  [2];
  logic [7:0] m_btn  [2];
  int         pend_n;
  logic [7:0] pend_w [2];
  logic       pend_t [2];

  task automatic model_reset();
    m_started = 0;
    pend_n    = 0;
    for (int p = 0; p < 2; p++) begin
      m_pres[p] = 0; m_good[p] = 0; m_bad[p] = 0; m_btn[p] = 8'h00;
    end
  endtask

  task automatic model_eval(output bit was_started);
    was_started = m_started;
    if (m_started && pend_n >= 8) begin
      for (int p = 0; p < 2; p++) begin
        m_btn[p] = ~pend_w[p];
        if (!m_pres[p]) begin
          m_good[p] = (pend_t[p] == 1'b0) ? m_good[p] + 1 : 0;
          if (m_good[p] == PRESENT_POLLS) begin
            m_pres[p] = 1; m_good[p] = 0; m_bad[p] = 0;
          end
        end else begin
          m_bad[p] = (pend_t[p] == 1'b1) ? m_bad[p] + 1 : 0;
          if (m_bad[p] == ABSENT_POLLS) begin
            m_pres[p] = 0; m_good[p] = 0; m_bad[p] = 0; m_btn[p] = 8'h00;
          end
        end
      end
    end
    m_started = 1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_25);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_present"}, jp_present, {m_pres[1], m_pres[0]});
    check_eq({tag, "_btn0"}, jp_buttons0, m_btn[0]);
    check_eq({tag, "_btn1"}, jp_buttons1, m_btn[1]);
    check_eq({tag, "_clean"}, jp_data_clean,
             {m_pres[1] ? jp_data_raw[1] : 1'b1, m_pres[0] ? jp_data_raw[0] : 1'b1});
  endtask

  task automatic latch_phase(input bit collide);
    bit exp_done;
    @(posedge clk_25); #1;
    jp_latch = 1'b1;
    if (collide) jp_clk = 2'b11;
    model_eval(exp_done);
    @(negedge clk_25);
    check_eq("done_early", jp_poll_done, 1'b0);
    @(negedge clk_25);
    check_eq("poll_done", jp_poll_done, exp_done);
    check_outputs("eval");
    @(negedge clk_25);
    check_eq("done_width", jp_poll_done, 1'b0);
    @(posedge clk_25); #1;
    jp_latch = 1'b0;
    jp_clk   = 2'b00;
  endtask

  task automatic clock_phase(input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input logic t0, input logic t1);
    jp_data_raw = {w1[0], w0[0]};
    step(8);
    for (int k = 0; k < n; k++) begin
      jp_clk = 2'b11;
      step(1);
      jp_clk = 2'b00;
      if (k < 7) jp_data_raw = {w1[k+1], w0[k+1]};
      else       jp_data_raw = {t1, t0};
      step(8);
    end
    pend_n    = n;
    pend_w[0] = w0; pend_w[1] = w1;
    pend_t[0] = t0; pend_t[1] = t1;
  endtask

  task automatic run_poll(input int n, input logic [7:0] w0, input logic [7:0] w1,
                          input logic t0, input logic t1, input bit collide);
    latch_phase(collide);
    clock_phase(n, w0, w1, t0, t1);
  endtask

  // Port1 must be present with its pin idle high.
  task automatic glitch(input int len, input bit drops);
    logic saved;
    saved = jp_data_raw[0];
    jp_data_raw[0] = 1'b1;
    step(8);
    check_eq("glitch_idle", jp_data_clean[0], 1'b1);
    jp_data_raw[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_25); #1;
      if (c == len) jp_data_raw[0] = 1'b1;
      @(negedge clk_25);
      if (!drops || c <= 5)
        check_eq($sformatf("glitch%0d_c%0d", len, c), jp_data_clean[0],
                 (drops && c == 5) ? 1'b0 : 1'b1);
    end
    step(6);
    jp_data_raw[0] = saved;
    step(8);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25);
      check_eq("rst_clean", jp_data_clean, 2'b11);
      check_eq("rst_present", jp_present, 2'b00);
      check_eq("rst_btn", {jp_buttons1, jp_buttons0}, 16'h0000);
      check_eq("rst_done", jp_poll_done, 1'b0);
    end
    @(posedge clk_25); #1;
    rst = 1'b0;
    jp_data_raw = 2'b11;
    step(8);

    // Plug-in: port1 holds A+Start, tail low; port2 floats high.
    run_poll(8, 8'hF6, 8'hFF, 1'b0, 1'b1, 0);
    run_poll(8, 8'hF6, 8'hFF, 1'b0, 1'b1, 0);
    run_poll(8, 8'hF6, 8'hFF, 1'b0, 1'b1, 0);
    check_eq("plugin_present", jp_present, 2'b01);
    check_eq("plugin_btn0", jp_buttons0, 8'h09);

    glitch(2, 0);
    glitch(3, 1);

    // Short poll, then one that is judged incomplete.
    run_poll(5, 8'h00, 8'hFF, 1'b0, 1'b1, 0);
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    check_eq("short_btn0", jp_buttons0, 8'h09);
    check_eq("short_present", jp_present, 2'b01);

    // Three bad tails then a good one keeps the pad; four bad tails drop it.
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    run_poll(8, 8'hF6, 8'hFF, 1'b0, 1'b1, 0);
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    check_eq("stay_present", jp_present, 2'b01);
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    run_poll(8, 8'h5A, 8'hFF, 1'b1, 1'b1, 0);
    check_eq("pre_unplug", jp_present, 2'b01);
    run_poll(8, 8'h3C, 8'hFF, 1'b0, 1'b1, 0);
    check_eq("unplug_present", jp_present, 2'b00);
    check_eq("unplug_btn0", jp_buttons0, 8'h00);

    // Collision: the clock edge that coincides with the latch must not shift in the tail.
    run_poll(8, 8'hA7, 8'h3C, 1'b0, 1'b0, 1);
    run_poll(8, 8'hA6, 8'h3D, 1'b0, 1'b0, 1);
    run_poll(8, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
    check_eq("collide_btn0", jp_buttons0, 8'h59);
    check_eq("collide_btn1", jp_buttons1, 8'hC2);

    for (int i = 0; i < 24; i++) begin
      int n;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : 8;
      run_poll(n, 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
               bit'($urandom_range(0, 5) == 0));
    end
    run_poll(8, 8'hF6, 8'h00, 1'b0, 1'b0, 0);
    run_poll(8, 8'hF6, 8'h00, 1'b0, 1'b0, 0);
    run_poll(8, 8'hF6, 8'h00, 1'b0, 1'b0, 0);
    check_eq("pre_rst_present", jp_present, 2'b11);

    // Mid-poll reset discards the partial poll and the started flag.
    latch_phase(0);
    clock_phase(4, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk_25); #1;
    rst = 1'b1;
    @(negedge clk_25);
    check_eq("midrst_clean", jp_data_clean, 2'b11);
    check_eq("midrst_present", jp_present, 2'b00);
    check_eq("midrst_btn", {jp_buttons1, jp_buttons0}, 16'h0000);
    step(2);
    rst = 1'b0;
    model_reset();
    step(8);
    run_poll(8, 8'hF6, 8'hF6, 1'b0, 1'b0, 0);
    run_poll(8, 8'hF6, 8'hF6, 1'b0, 1'b0, 0);
    latch_phase(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
